// File: rtl/video_coord_gen.sv
// rtl/video_coord_gen.sv - sync stream to registered pixel coordinates with frame measurement and lock tracking
//
// Ports:
//   clk, reset (async, active-low)
//   pix_en       pixel strobe; everything below is sampled only when high
//   vs_in        vertical sync, active level given by VS_POL
//   de_in        active-video data enable (active-high)
//   gr_x, gr_y   column/row of the last sampled active pixel
//   en           one-clk strobe for a valid active pixel while locked
//   frame_start  one-clk pulse per active vsync edge
//   locked       input geometry is stable
//   err          one-clk pulse when lock is lost
//   meas_w/h     reference active width/height

module video_coord_gen #(
    parameter logic VS_POL      = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        vs_in,
    input  logic        de_in,
    output logic [10:0] gr_x,
    output logic [9:0]  gr_y,
    output logic        en,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [10:0] meas_w,
    output logic [9:0]  meas_h
);

    localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {ST_SEARCH, ST_CHECK, ST_LOCKED} state_t;

    state_t      state;
    logic        vs_prev;
    logic        de_prev;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic [10:0] frame_w;
    logic        frame_bad;
    logic [2:0]  good_cnt;

    logic        vs_act;
    logic        vs_edge;
    logic        de_fall;
    logic        first_line;
    logic        line_diff;
    logic [9:0]  y_eff;
    logic [10:0] w_eff;
    logic        bad_eff;
    logic        frame_ok;
    logic        same_size;
    logic        line_err;
    logic        close_err;

    // The *_eff values fold a line end into the frame statistics so that a
    // de fall coinciding with the vsync edge is counted in the closing frame.
    always_comb begin
        vs_act     = (vs_in == VS_POL);
        vs_edge    = vs_act & ~vs_prev;
        de_fall    = de_prev & ~de_in;
        first_line = (y_cnt == 10'd0);
        line_diff  = de_fall & ~first_line & (x_cnt != frame_w);
        y_eff      = y_cnt;
        if (de_fall && (y_cnt != 10'h3ff)) begin
            y_eff = y_cnt + 10'd1;
        end
        w_eff      = (de_fall && first_line) ? x_cnt : frame_w;
        bad_eff    = frame_bad | line_diff;
        frame_ok   = ~bad_eff & (y_eff != 10'd0);
        same_size  = (w_eff == meas_w) && (y_eff == meas_h);
        line_err   = de_fall & (x_cnt != meas_w);
        close_err  = vs_edge & ((y_eff != meas_h) | bad_eff);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_SEARCH;
            vs_prev     <= 1'b0;
            de_prev     <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            frame_w     <= '0;
            frame_bad   <= 1'b0;
            good_cnt    <= '0;
            gr_x        <= '0;
            gr_y        <= '0;
            en          <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            meas_w      <= '0;
            meas_h      <= '0;
        end else begin
            en          <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            if (pix_en) begin
                vs_prev     <= vs_act;
                de_prev     <= de_in;
                frame_start <= vs_edge;
                en          <= de_in & (state == ST_LOCKED) & ~(line_err | close_err);

                if (de_in) begin
                    gr_x <= x_cnt;
                    gr_y <= y_cnt;
                    if (x_cnt != 11'h7ff) begin
                        x_cnt <= x_cnt + 11'd1;
                    end
                end

                if (de_fall) begin
                    x_cnt <= '0;
                    y_cnt <= y_eff;
                    if (first_line) begin
                        frame_w <= x_cnt;
                    end
                    if (line_diff) begin
                        frame_bad <= 1'b1;
                    end
                end

                // Frame close overrides the line-end updates above.
                if (vs_edge) begin
                    y_cnt     <= '0;
                    frame_w   <= '0;
                    frame_bad <= 1'b0;
                end

                case (state)
                    ST_SEARCH: begin
                        if (vs_edge) begin
                            state    <= ST_CHECK;
                            good_cnt <= '0;
                        end
                    end
                    ST_CHECK: begin
                        if (vs_edge) begin
                            if (frame_ok && ((good_cnt == 3'd0) || same_size)) begin
                                meas_w   <= w_eff;
                                meas_h   <= y_eff;
                                good_cnt <= good_cnt + 3'd1;
                                if ((good_cnt + 3'd1) == LOCK_N) begin
                                    state  <= ST_LOCKED;
                                    locked <= 1'b1;
                                end
                            end else if (frame_ok) begin
                                meas_w   <= w_eff;
                                meas_h   <= y_eff;
                                good_cnt <= 3'd1;
                            end else begin
                                good_cnt <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (line_err || close_err) begin
                            err      <= 1'b1;
                            locked   <= 1'b0;
                            state    <= ST_SEARCH;
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= ST_SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_coord_gen.sv
// tb/tb_video_coord_gen.sv - randomized bench for video_coord_gen against a frame-level reference model

module tb_video_coord_gen;

    localparam int LOCK_FRAMES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_en = 1'b0;
    logic        vs_lvl = 1'b0;
    logic        de_in = 1'b0;
    logic        vs_low;

    logic [10:0] a_gr_x, b_gr_x, a_meas_w, b_meas_w;
    logic [9:0]  a_gr_y, b_gr_y, a_meas_h, b_meas_h;
    logic        a_en, b_en, a_fs, b_fs, a_locked, b_locked, a_err, b_err;

    assign vs_low = ~vs_lvl;

    always #5 clk = ~clk;

    video_coord_gen #(.VS_POL(1'b1), .LOCK_FRAMES(LOCK_FRAMES)) u_dut_hi (
        .clk(clk), .reset(reset), .pix_en(pix_en), .vs_in(vs_lvl), .de_in(de_in),
        .gr_x(a_gr_x), .gr_y(a_gr_y), .en(a_en), .frame_start(a_fs),
        .locked(a_locked), .err(a_err), .meas_w(a_meas_w), .meas_h(a_meas_h)
    );

    video_coord_gen #(.VS_POL(1'b0), .LOCK_FRAMES(LOCK_FRAMES)) u_dut_lo (
        .clk(clk), .reset(reset), .pix_en(pix_en), .vs_in(vs_low), .de_in(de_in),
        .gr_x(b_gr_x), .gr_y(b_gr_y), .en(b_en), .frame_start(b_fs),
        .locked(b_locked), .err(b_err), .meas_w(b_meas_w), .meas_h(b_meas_h)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;
    int en_cnt   = 0;
    int err_cnt  = 0;

    // reference model: frame described as a list of finished line widths
    int m_pix;
    int m_widths[$];
    int m_phase;          // 0 search, 1 check, 2 locked
    int m_good;
    int m_ref_w, m_ref_h;
    bit m_vs_prev, m_de_prev;
    int e_gr_x, e_gr_y, e_en, e_fs, e_locked, e_err;

    task automatic chk(string tag, int obs, int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int sat(int v, int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        m_pix = 0; m_widths.delete(); m_phase = 0; m_good = 0;
        m_ref_w = 0; m_ref_h = 0; m_vs_prev = 0; m_de_prev = 0;
        e_gr_x = 0; e_gr_y = 0; e_en = 0; e_fs = 0; e_locked = 0; e_err = 0;
    endtask

    task automatic model_idle();
        e_en = 0; e_fs = 0; e_err = 0;
    endtask

    task automatic model_sample(bit v, bit d);
        int ph0, h, fw, w;
        bit drop, all_eq;
        ph0 = m_phase; drop = 0;
        e_en = 0; e_fs = 0; e_err = 0;
        if (d) begin
            e_gr_x = sat(m_pix, 2047);
            e_gr_y = sat(m_widths.size(), 1023);
            m_pix++;
            e_en = (ph0 == 2);
        end
        if (m_de_prev && !d) begin
            w = sat(m_pix, 2047);
            m_widths.push_back(w);
            if (ph0 == 2 && w != m_ref_w) drop = 1;
            m_pix = 0;
        end
        if (v && !m_vs_prev) begin
            e_fs = 1;
            h = sat(m_widths.size(), 1023);
            fw = (m_widths.size() > 0) ? m_widths[0] : 0;
            all_eq = 1;
            foreach (m_widths[i]) if (m_widths[i] != fw) all_eq = 0;
            if (ph0 == 0) begin
                m_phase = 1; m_good = 0;
            end else if (ph0 == 1) begin
                if (h > 0 && all_eq && (m_good == 0 || (fw == m_ref_w && h == m_ref_h))) begin
                    m_ref_w = fw; m_ref_h = h; m_good++;
                    if (m_good == LOCK_FRAMES) m_phase = 2;
                end else if (h > 0 && all_eq) begin
                    m_ref_w = fw; m_ref_h = h; m_good = 1;
                end else begin
                    m_good = 0;
                end
            end else begin
                if (h != m_ref_h || !all_eq) drop = 1;
            end
            m_widths.delete();
        end
        if (drop) begin
            e_err = 1; e_en = 0; m_phase = 0; m_good = 0;
        end
        e_locked = (m_phase == 2);
        m_vs_prev = v; m_de_prev = d;
    endtask

    task automatic check_outputs();
        chk("hi.gr_x", int'(a_gr_x), e_gr_x);
        chk("hi.gr_y", int'(a_gr_y), e_gr_y);
        chk("hi.en", int'(a_en), e_en);
        chk("hi.frame_start", int'(a_fs), e_fs);
        chk("hi.locked", int'(a_locked), e_locked);
        chk("hi.err", int'(a_err), e_err);
        chk("hi.meas_w", int'(a_meas_w), m_ref_w);
        chk("hi.meas_h", int'(a_meas_h), m_ref_h);
        chk("lo.gr_x", int'(b_gr_x), e_gr_x);
        chk("lo.gr_y", int'(b_gr_y), e_gr_y);
        chk("lo.en", int'(b_en), e_en);
        chk("lo.frame_start", int'(b_fs), e_fs);
        chk("lo.locked", int'(b_locked), e_locked);
        chk("lo.err", int'(b_err), e_err);
        chk("lo.meas_w", int'(b_meas_w), m_ref_w);
        chk("lo.meas_h", int'(b_meas_h), m_ref_h);
    endtask

    task automatic step(bit pe, bit v, bit d);
        pix_en = pe; vs_lvl = v; de_in = d;
        @(posedge clk);
        if (reset) begin
            if (pe) model_sample(v, d);
            else model_idle();
        end
        @(negedge clk);
        check_outputs();
        if (a_en) en_cnt++;
        if (a_err) err_cnt++;
    endtask

    task automatic send_sample(bit v, bit d);
        if (mode == 1) begin
            step(1'b0, 1'($urandom), 1'($urandom));
        end else if (mode == 2) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 1'($urandom));
        end
        step(1'b1, v, d);
    endtask

    task automatic send_frame(int n, int w, int bad_idx, int bad_w);
        repeat (2) send_sample(1'b1, 1'b0);
        repeat (2) send_sample(1'b0, 1'b0);
        for (int l = 0; l < n; l++) begin
            int lw;
            lw = (l == bad_idx) ? bad_w : w;
            repeat (lw) send_sample(1'b0, 1'b1);
            repeat (4) send_sample(1'b0, 1'b0);
        end
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, ".hi_outs"}, int'({a_gr_x, a_gr_y, a_en, a_fs, a_locked, a_err, a_meas_w, a_meas_h}), 0);
        chk({tag, ".lo_outs"}, int'({b_gr_x, b_gr_y, b_en, b_fs, b_locked, b_err, b_meas_w, b_meas_h}), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_all_zero("reset");
        reset = 1'b1;

        // lock on 8x4 frames, then one full locked frame
        mode = 0;
        repeat (3) send_frame(4, 8, -1, 0);
        chk("locked_after_3_edges", int'(a_locked), 1);
        en_cnt = 0;
        send_frame(4, 8, -1, 0);
        chk("en_count_locked_frame", en_cnt, 32);
        chk("meas_w_8", int'(a_meas_w), 8);
        chk("meas_h_4", int'(a_meas_h), 4);

        // short line while locked, then relock
        err_cnt = 0;
        send_frame(4, 8, 1, 7);
        chk("err_pulses_short_line", err_cnt, 1);
        chk("locked_after_err", int'(a_locked), 0);
        en_cnt = 0;
        repeat (2) send_frame(4, 8, -1, 0);
        chk("no_en_before_relock", en_cnt, 0);
        send_frame(4, 8, -1, 0);
        chk("relocked", int'(a_locked), 1);

        // pix_en every other clk
        mode = 1;
        repeat (3) send_frame(4, 8, -1, 0);
        en_cnt = 0;
        send_frame(4, 8, -1, 0);
        chk("en_count_half_rate", en_cnt, 32);

        // random geometry, random strobe gaps
        mode = 2;
        for (int f = 0; f < 24; f++) begin
            int n, w, bi, bw;
            n  = $urandom_range(1, 5);
            w  = $urandom_range(2, 12);
            bi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            bw = ($urandom_range(0, 1) == 0) ? w + 1 : w - 1;
            if (f >= 16) begin
                n = 3; w = 6; bi = -1;
            end
            send_frame(n, w, bi, bw);
        end

        // saturating line width
        mode = 0;
        repeat (5) send_frame(1, 2100, -1, 0);
        chk("gr_x_saturated", int'(a_gr_x), 2047);
        chk("meas_w_saturated", int'(a_meas_w), 2047);
        chk("locked_wide", int'(a_locked), 1);

        // async reset mid-frame while locked
        repeat (5) send_frame(4, 8, -1, 0);
        chk("locked_before_reset", int'(a_locked), 1);
        repeat (2) send_sample(1'b1, 1'b0);
        repeat (2) send_sample(1'b0, 1'b0);
        repeat (5) send_sample(1'b0, 1'b1);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        repeat (2) step(1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        repeat (2) send_sample(1'b0, 1'b1);
        repeat (4) send_sample(1'b0, 1'b0);
        chk("search_after_reset", int'(a_locked), 0);
        repeat (3) send_frame(4, 8, -1, 0);
        chk("relocked_after_reset", int'(a_locked), 1);
        chk("meas_w_after_reset", int'(a_meas_w), 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
